alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
In-order issue controller between decode and the ALU execute stage. It tracks in-flight register writes in a small scoreboard FIFO and stalls decode on RAW hazards against any pending destination. It gates the valid/next handshake into the ALU, retires entries on writeback, and kills the decode-slot instruction on a branch flush.

Parameters:
DEPTH, 4, max in-flight register-writing instructions (power of 2, 2..16)
AW, 2, pointer width = log2(DEPTH)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
d_valid  in  1  decode offers instruction
d_next  out  1  controller accepts decode instruction this cycle
d_rs1en  in  1  rs1 is read
d_rs2en  in  1  rs2 is read
d_rs1_addr  in  5  rs1 index
d_rs2_addr  in  5  rs2 index
d_regen  in  1  instruction writes rd
d_rd  in  5  destination index
a_valid  out  1  issue to ALU (i_valid of execute)
a_next  in  1  ALU ready (i_next of execute)
c_flush  in  1  branch/jump flush from execute
w_valid  in  1  writeback retires one register write
w_rd  in  5  retiring destination
o_busy  out  32  per-register pending bitmap, bit0 always 0
o_count  out  AW+1  entries in flight
o_err  out  1  sticky protocol error

Behaviour:
- Reset (rst_n=0 at posedge): FIFO empty, rd/wr pointers 0, o_count=0, o_err=0. Outputs are combinational from cleared state: o_busy=0, a_valid=0 unless d_valid.
- Pop first: pop = w_valid & (o_count!=0). Entries visible for hazard = FIFO contents excluding head when pop=1 (same-cycle retire bypass).
- hazard = (d_rs1en & rs1!=0 & rs1 matches visible entry) | (d_rs2en & rs2!=0 & rs2 matches visible entry).
- full = (o_count==DEPTH) & ~pop.
- stall = hazard | (d_regen & d_rd!=0 & full) | c_flush.
- a_valid = d_valid & ~stall; d_next = a_next & ~stall; issue = a_valid & a_next.
- push = issue & d_regen & d_rd!=0; writes d_rd at wr pointer.
- Pointers wrap modulo DEPTH. o_count next = o_count + push - pop; simultaneous push+pop at full is legal and count stays DEPTH.
- o_busy[r]=1 iff r != 0 and r is held by any valid entry, head included (registered view, no bypass).
- Retire check: w_valid with o_count==0, or pop with head rd != w_rd -> o_err<=1 (sticky until reset); an empty-FIFO retire does not pop.
- c_flush: decode-slot instruction not issued that cycle (decode is expected to drop it); FIFO untouched, since instructions already issued still retire. Pops still happen during c_flush.
- Duplicate rd entries allowed (WAW); a register stays busy until its last entry retires.
- Reset mid-operation discards all entries; a w_valid in the reset cycle is ignored.
- Latency: zero-cycle combinational issue decision; scoreboard update visible the next cycle.

Optional Feature:
ALU_ISSUE_STATS_EN: when defined, adds outputs o_stall_haz (32) and o_stall_full (32). These are free-running, saturating counters of cycles with d_valid & hazard and d_valid & full & ~hazard; reset to 0. When undefined, the ports and counters are absent, and behaviour is otherwise identical.

Test Plan:
- Issue x5 write (d_regen=1,d_rd=5), next cycle instr reads rs1=5 -> a_valid=0, d_next=0; w_valid,w_rd=5 -> same cycle a_valid=1; o_busy[5] clears next cycle.
- Write to x0 then read x0 -> no push, o_count=0, no stall.
- Issue 4 writes x1..x4 with no retire -> o_count=4, 5th writer x6 stalls; same cycle w_rd=1 -> 5th issues, o_count stays 4.
- c_flush=1 with d_valid=1, no hazard -> a_valid=0, d_next=0, o_count unchanged; retire during flush decrements o_count.
- w_valid with w_rd=7 while head is 3 -> o_err=1 and stays 1; w_valid on empty FIFO -> o_err=1, o_count stays 0.
- Two writers to x9, retire first -> o_busy[9] still 1; retire second -> 0; rst_n=0 with 3 entries -> o_count=0, o_busy=0 next cycle.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// -----------------------------------------------------------------------------
// alu_issue_ctrl
//
// In-order issue controller that sits between decode and the ALU execute stage.
// A small scoreboard FIFO records the destination register of every issued
// register-writing instruction until writeback retires it. Decode is stalled
// on a read-after-write hazard against any pending destination, when the
// scoreboard is full, or while a branch flush is signalled.
//
// Optional build macro:
//   ALU_ISSUE_STATS_EN - adds saturating stall statistics counters
//                        (o_stall_haz, o_stall_full).
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   d_valid / d_next    decode offer / controller accept
//   d_rs1en, d_rs1_addr first source operand enable and index
//   d_rs2en, d_rs2_addr second source operand enable and index
//   d_regen, d_rd       instruction writes rd, destination index
//   a_valid / a_next    issue handshake towards the ALU
//   c_flush             branch/jump flush from execute
//   w_valid, w_rd       writeback retires one register write
//   o_busy              per-register pending bitmap (bit 0 always 0)
//   o_count             scoreboard entries in flight
//   o_err               sticky retire protocol error
//   o_stall_haz         (stats build) cycles with d_valid and a hazard
//   o_stall_full        (stats build) cycles with d_valid, full, no hazard
// -----------------------------------------------------------------------------
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          d_valid,
    output logic          d_next,
    input  logic          d_rs1en,
    input  logic          d_rs2en,
    input  logic [4:0]    d_rs1_addr,
    input  logic [4:0]    d_rs2_addr,
    input  logic          d_regen,
    input  logic [4:0]    d_rd,
    output logic          a_valid,
    input  logic          a_next,
    input  logic          c_flush,
    input  logic          w_valid,
    input  logic [4:0]    w_rd,
    output logic [31:0]   o_busy,
    output logic [AW:0]   o_count,
    output logic          o_err
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0]   o_stall_haz,
    output logic [31:0]   o_stall_full
`endif
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [4:0]    rd_mem_q [DEPTH];
    logic [4:0]    rd_mem_d [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          err_q,    err_d;

    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_visible;
    logic [AW-1:0]    ent_off;
    logic [4:0]       head_rd;
    logic             pop;
    logic             push;
    logic             issue;
    logic             hazard;
    logic             full;
    logic             stall;
    logic             rs1_hit;
    logic             rs2_hit;
    logic [31:0]      busy;

    // Entry i is live when its distance from the read pointer is below the
    // occupancy. When the head retires this cycle it is hidden from the hazard
    // check so a dependent instruction can issue in the same cycle.
    always_comb begin
        ent_valid   = '0;
        ent_visible = '0;
        ent_off     = '0;
        head_rd     = rd_mem_q[rd_ptr_q];
        pop         = w_valid & (count_q != '0);
        for (int i = 0; i < DEPTH; i++) begin
            ent_off        = AW'(i) - rd_ptr_q;
            ent_valid[i]   = ({1'b0, ent_off} < count_q);
            ent_visible[i] = ent_valid[i] & ~(pop & (AW'(i) == rd_ptr_q));
        end
    end

    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_visible[i] && rd_mem_q[i] == d_rs1_addr) rs1_hit = 1'b1;
            if (ent_visible[i] && rd_mem_q[i] == d_rs2_addr) rs2_hit = 1'b1;
        end
        hazard = (d_rs1en & (d_rs1_addr != 5'd0) & rs1_hit)
               | (d_rs2en & (d_rs2_addr != 5'd0) & rs2_hit);
        full   = (count_q == DEPTH_C) & ~pop;
        stall  = hazard | (d_regen & (d_rd != 5'd0) & full) | c_flush;
        a_valid = d_valid & ~stall;
        d_next  = a_next & ~stall;
        issue   = a_valid & a_next;
        push    = issue & d_regen & (d_rd != 5'd0);
    end

    always_comb begin
        rd_mem_d = rd_mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (push) begin
            rd_mem_d[wr_ptr_q] = d_rd;
            wr_ptr_d           = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        // An empty-FIFO retire or an out-of-order destination is a protocol
        // violation by writeback; it latches until reset.
        err_d   = err_q | (w_valid & (count_q == '0))
                        | (pop & (head_rd != w_rd));
    end

    // Registered view of the scoreboard: the head is still busy in the cycle
    // it retires.
    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) busy[rd_mem_q[i]] = 1'b1;
        end
        busy[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) rd_mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rd_mem_q <= rd_mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            err_q    <= err_d;
        end
    end

    assign o_busy  = busy;
    assign o_count = count_q;
    assign o_err   = err_q;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stall_haz_q,  stall_haz_d;
    logic [31:0] stall_full_q, stall_full_d;

    always_comb begin
        stall_haz_d  = stall_haz_q;
        stall_full_d = stall_full_q;
        if (d_valid && hazard && !(&stall_haz_q))
            stall_haz_d = stall_haz_q + 32'd1;
        if (d_valid && full && !hazard && !(&stall_full_q))
            stall_full_d = stall_full_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_haz_q  <= '0;
            stall_full_q <= '0;
        end else begin
            stall_haz_q  <= stall_haz_d;
            stall_full_q <= stall_full_d;
        end
    end

    assign o_stall_haz  = stall_haz_q;
    assign o_stall_full = stall_full_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        d_valid, d_next;
    logic        d_rs1en, d_rs2en;
    logic [4:0]  d_rs1_addr, d_rs2_addr;
    logic        d_regen;
    logic [4:0]  d_rd;
    logic        a_valid, a_next;
    logic        c_flush;
    logic        w_valid;
    logic [4:0]  w_rd;
    logic [31:0] o_busy;
    logic [2:0]  o_count;
    logic        o_err;
`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] o_stall_haz, o_stall_full;
`endif

    int checks = 0;
    int errors = 0;
    int sb[$];      // expected in-flight destinations, oldest first
    bit m_err;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .d_valid(d_valid), .d_next(d_next),
        .d_rs1en(d_rs1en), .d_rs2en(d_rs2en),
        .d_rs1_addr(d_rs1_addr), .d_rs2_addr(d_rs2_addr),
        .d_regen(d_regen), .d_rd(d_rd),
        .a_valid(a_valid), .a_next(a_next),
        .c_flush(c_flush), .w_valid(w_valid), .w_rd(w_rd),
        .o_busy(o_busy), .o_count(o_count), .o_err(o_err)
`ifdef ALU_ISSUE_STATS_EN
        , .o_stall_haz(o_stall_haz), .o_stall_full(o_stall_full)
`endif
    );

    function automatic bit m_pop();
        return w_valid && sb.size() != 0;
    endfunction

    function automatic bit m_hazard();
        bit h = 1'b0;
        int start = m_pop() ? 1 : 0;
        for (int i = start; i < sb.size(); i++) begin
            if (d_rs1en && d_rs1_addr != 0 && sb[i] == int'(d_rs1_addr)) h = 1'b1;
            if (d_rs2en && d_rs2_addr != 0 && sb[i] == int'(d_rs2_addr)) h = 1'b1;
        end
        return h;
    endfunction

    function automatic bit m_stall();
        bit full = (sb.size() == 4) && !m_pop();
        return m_hazard() || (d_regen && d_rd != 0 && full) || c_flush;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        foreach (sb[i]) b[sb[i]] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic idle();
        d_valid = 0; d_rs1en = 0; d_rs2en = 0; d_rs1_addr = 0; d_rs2_addr = 0;
        d_regen = 0; d_rd = 0; a_next = 1; c_flush = 0; w_valid = 0; w_rd = 0;
    endtask

    // Advance one clock; the scoreboard absorbs what the current inputs imply.
    task automatic tick();
        bit pop, iss;
        if (!rst_n) begin
            sb.delete();
            m_err = 1'b0;
        end else begin
            pop = m_pop();
            iss = d_valid && !m_stall() && a_next;
            if (w_valid && (sb.size() == 0 || sb[0] != int'(w_rd))) m_err = 1'b1;
            if (pop) void'(sb.pop_front());
            if (iss && d_regen && d_rd != 0) sb.push_back(int'(d_rd));
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        tick();
        rst_n = 1;
    endtask

    task automatic write_rd(input logic [4:0] r);
        idle();
        d_valid = 1; d_regen = 1; d_rd = r;
        tick();
        idle();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", o_count); end
        checks++; if (o_busy !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", o_busy); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
        checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_avalid got %b want 0", a_valid); end
        d_valid = 1; #1;
        checks++; if (a_valid !== 1'b1 || d_next !== 1'b1) begin errors++;
            $display("FAIL reset_issue got a_valid=%b d_next=%b want 1 1", a_valid, d_next); end
        idle();
    endtask

    task automatic test_raw();
        write_rd(5);
        checks++; if (o_count !== 3'd1 || o_busy[5] !== 1'b1) begin errors++;
            $display("FAIL raw_push got count=%0d busy5=%b want 1 1", o_count, o_busy[5]); end
        d_valid = 1; d_rs1en = 1; d_rs1_addr = 5; #1;
        checks++; if (a_valid !== 1'b0 || d_next !== 1'b0) begin errors++;
            $display("FAIL raw_stall got a_valid=%b d_next=%b want 0 0", a_valid, d_next); end
        w_valid = 1; w_rd = 5; #1;
        checks++; if (a_valid !== 1'b1 || d_next !== 1'b1) begin errors++;
            $display("FAIL raw_bypass got a_valid=%b d_next=%b want 1 1", a_valid, d_next); end
        checks++; if (o_busy[5] !== 1'b1) begin errors++;
            $display("FAIL raw_busy_reg got %b want 1", o_busy[5]); end
        tick(); idle();
        checks++; if (o_busy !== 32'd0 || o_count !== 3'd0 || o_err !== 1'b0) begin errors++;
            $display("FAIL raw_retire got busy=%h count=%0d err=%b want 0 0 0", o_busy, o_count, o_err); end
    endtask

    task automatic test_x0();
        write_rd(0);
        checks++; if (o_count !== 3'd0 || o_busy !== 32'd0) begin errors++;
            $display("FAIL x0_push got count=%0d busy=%h want 0 0", o_count, o_busy); end
        d_valid = 1; d_rs1en = 1; d_rs1_addr = 0; d_rs2en = 1; d_rs2_addr = 0; #1;
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL x0_read got a_valid=%b want 1", a_valid); end
        idle();
    endtask

    task automatic test_full();
        for (int r = 1; r <= 4; r++) write_rd(5'(r));
        checks++; if (o_count !== 3'd4) begin errors++; $display("FAIL full_count got %0d want 4", o_count); end
        d_valid = 1; d_regen = 1; d_rd = 6; #1;
        checks++; if (a_valid !== 1'b0 || d_next !== 1'b0) begin errors++;
            $display("FAIL full_stall got a_valid=%b d_next=%b want 0 0", a_valid, d_next); end
        w_valid = 1; w_rd = 1; #1;
        checks++; if (a_valid !== 1'b1) begin errors++; $display("FAIL full_pushpop got a_valid=%b want 1", a_valid); end
        tick(); idle();
        checks++; if (o_count !== 3'd4 || o_busy !== 32'h0000_005C) begin errors++;
            $display("FAIL full_after got count=%0d busy=%h want 4 0000005c", o_count, o_busy); end
        while (sb.size() != 0) begin
            w_valid = 1; w_rd = 5'(sb[0]);
            tick();
        end
        idle();
        checks++; if (o_count !== 3'd0 || o_err !== 1'b0) begin errors++;
            $display("FAIL full_drain got count=%0d err=%b want 0 0", o_count, o_err); end
    endtask

    task automatic test_flush();
        write_rd(7);
        d_valid = 1; d_rs1en = 1; d_rs1_addr = 8; c_flush = 1; #1;
        checks++; if (a_valid !== 1'b0 || d_next !== 1'b0) begin errors++;
            $display("FAIL flush_kill got a_valid=%b d_next=%b want 0 0", a_valid, d_next); end
        tick();
        checks++; if (o_count !== 3'd1) begin errors++; $display("FAIL flush_hold got %0d want 1", o_count); end
        w_valid = 1; w_rd = 7;
        tick(); idle();
        checks++; if (o_count !== 3'd0 || o_err !== 1'b0) begin errors++;
            $display("FAIL flush_pop got count=%0d err=%b want 0 0", o_count, o_err); end
    endtask

    task automatic test_waw();
        write_rd(9); write_rd(9);
        w_valid = 1; w_rd = 9; tick(); idle();
        checks++; if (o_busy[9] !== 1'b1 || o_count !== 3'd1) begin errors++;
            $display("FAIL waw_first got busy9=%b count=%0d want 1 1", o_busy[9], o_count); end
        w_valid = 1; w_rd = 9; tick(); idle();
        checks++; if (o_busy[9] !== 1'b0 || o_count !== 3'd0) begin errors++;
            $display("FAIL waw_last got busy9=%b count=%0d want 0 0", o_busy[9], o_count); end
    endtask

    task automatic test_err();
        write_rd(3);
        w_valid = 1; w_rd = 7; tick(); idle();
        checks++; if (o_err !== 1'b1 || o_count !== 3'd0) begin errors++;
            $display("FAIL err_mismatch got err=%b count=%0d want 1 0", o_err, o_count); end
        tick();
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", o_err); end
        do_reset();
        w_valid = 1; w_rd = 4; tick(); idle();
        checks++; if (o_err !== 1'b1 || o_count !== 3'd0) begin errors++;
            $display("FAIL err_empty got err=%b count=%0d want 1 0", o_err, o_count); end
        do_reset();
    endtask

    task automatic test_reset_mid();
        write_rd(10); write_rd(11); write_rd(12);
        checks++; if (o_count !== 3'd3) begin errors++; $display("FAIL mid_fill got %0d want 3", o_count); end
        rst_n = 0; w_valid = 1; w_rd = 10;
        tick();
        rst_n = 1; idle(); #1;
        checks++; if (o_count !== 3'd0 || o_busy !== 32'd0 || o_err !== 1'b0) begin errors++;
            $display("FAIL mid_reset got count=%0d busy=%h err=%b want 0 0 0", o_count, o_busy, o_err); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            d_valid    = 1'($urandom_range(0, 1));
            d_rs1en    = 1'($urandom_range(0, 1));
            d_rs2en    = 1'($urandom_range(0, 1));
            d_rs1_addr = 5'($urandom_range(0, 7));
            d_rs2_addr = 5'($urandom_range(0, 7));
            d_regen    = 1'($urandom_range(0, 1));
            d_rd       = 5'($urandom_range(0, 7));
            a_next     = ($urandom_range(0, 3) != 0);
            c_flush    = ($urandom_range(0, 9) == 0);
            w_valid    = (sb.size() != 0) && ($urandom_range(0, 2) == 0);
            w_rd       = (sb.size() != 0) ? 5'(sb[0]) : 5'd0;
            #1;
            checks++; if (a_valid !== (d_valid && !m_stall()) || d_next !== (a_next && !m_stall())) begin errors++;
                $display("FAIL rand_hs cyc %0d got a_valid=%b d_next=%b want %b %b", n, a_valid, d_next,
                         d_valid && !m_stall(), a_next && !m_stall()); end
            checks++; if (o_count !== 3'(sb.size()) || o_busy !== m_busy() || o_err !== m_err) begin errors++;
                $display("FAIL rand_state cyc %0d got count=%0d busy=%h err=%b want %0d %h %b",
                         n, o_count, o_busy, o_err, sb.size(), m_busy(), m_err); end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 0;
        m_err = 0;
        tick();
        test_reset();
        test_raw();
        test_x0();
        test_full();
        test_flush();
        test_waw();
        test_err();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
